down_counter_74x191: RTL and testbench
======================================

DOWN_COUNTER_74X191 -- requirements
Module: down_counter_74x191

Interface
REQ-001 Parameter AUTO_RELOAD, default 0: 0 = wrap 0000->1111 on underflow; 1 = reload from reload register on underflow.
REQ-002 Parameter RELOAD_INIT, default 4'b1111: reset value of the internal reload register.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 clr  input  1  async active-high clear.
REQ-005 ld_bar  input  1  sync load, active low.
REQ-006 ent  input  1  enable T; also gates rbo.
REQ-007 enp  input  1  enable P.
REQ-008 a, b, c, d  input  1 each  parallel load data; a = LSB, d = MSB.
REQ-009 qa, qb, qc, qd  output  1 each  registered count; qa = LSB, qd = MSB.
REQ-010 rbo  output  1  ripple borrow out, combinational: ent & ~qa & ~qb & ~qc & ~qd.
REQ-011 tc  output  1  registered terminal-count pulse, high for 1 cycle after an underflow step.

Function
REQ-012 Count value {qd,qc,qb,qa} is an unsigned 4-bit quantity.
REQ-013 count_enable = ent & enp.
REQ-014 Per rising clk edge (clr low), priority: load > count-down > hold.
REQ-015 Load (ld_bar=0): count <= {d,c,b,a}; reload register <= {d,c,b,a}; independent of ent/enp; tc <= 0.
REQ-016 Count (ld_bar=1, count_enable=1, count != 0): count <= count - 1; tc <= 0.
REQ-017 Underflow (ld_bar=1, count_enable=1, count == 0): count <= 4'b1111 if AUTO_RELOAD=0, else reload register value; tc <= 1.
REQ-018 Hold (ld_bar=1, count_enable=0): count and reload register unchanged; tc <= 0.
REQ-019 tc never high two consecutive cycles unless underflow repeats each cycle (AUTO_RELOAD=1 with reload value 0).
REQ-020 Reload value 0 with AUTO_RELOAD=1: every enabled cycle is an underflow; count stays 0; tc stays high.
REQ-021 Load in the same cycle count == 0 and count_enable=1: load wins; tc <= 0.
REQ-022 rbo follows count and ent with no clock delay; it is not gated by enp (allows cascading: rbo of stage N -> ent of stage N+1).
REQ-023 Divider use: with AUTO_RELOAD=1 and reload value R, tc pulses once every R+1 enabled cycles.

Reset
REQ-024 clr=1 asynchronously forces count to 0000, tc to 0, and reload register to RELOAD_INIT, with no clock required.
REQ-025 While clr=1, load and count are ignored.
REQ-026 rbo = ent during reset, because count = 0.
REQ-027 Deassertion mid-operation: the first rising edge with clr=0 is evaluated normally from count 0000, so an enabled edge underflows and pulses tc.

Structure
REQ-028 Shared package constants:
  - CNT_W = 4
  - CNT_ZERO = 4'b0000
  - CNT_MAX = 4'b1111
REQ-029 The shared package holds no typedefs beyond the count vector type.
REQ-030 One sub-module, down_counter_cell: a 4-bit register with load, decrement and underflow detect.
REQ-031 The top level holds the reload register, tc flop and rbo logic.
REQ-032 RTL size target: 120-250 lines including the self-checking testbench module testbench.

Verification
REQ-033 Async clear: count=0110, assert clr between edges -> count=0000 and tc=0 immediately; rbo=ent.
REQ-034 Free count, AUTO_RELOAD=0:
  - stimulus: load 0011, ent=enp=1
  - required: counts 0010, 0001, 0000, 1111, 1110
  - required: rbo=1 only while count=0000
  - required: tc=1 only in the cycle after 0000->1111
REQ-035 Enable gating: count=0101.
  - enp=0, 3 edges -> count holds at 0101, tc=0
  - ent=0 at count=0000 -> rbo=0
REQ-036 Load/underflow collision: count=0000, ent=enp=1, ld_bar=0 with data 1010 -> count=1010, tc=0.
REQ-037 Divider, AUTO_RELOAD=1: load 0100, enable continuously -> tc pulses every 5 cycles; count sequence 0100->0000 repeats.
REQ-038 Reset mid-count, AUTO_RELOAD=1:
  - stimulus: load 0111, count 2 cycles, pulse clr
  - required: reload register = RELOAD_INIT, count = 0000
  - required: next enabled edge -> count=1111, tc=1

Source files
------------

// File: rtl/down_counter_74x191_pkg.sv
// Shared constants and the count vector type for the 74x191-style down counter.
package down_counter_74x191_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ZERO = 4'b0000;
  localparam cnt_t CNT_MAX  = 4'b1111;

endpackage : down_counter_74x191_pkg

// File: rtl/down_counter_cell.sv
// 4-bit count register with synchronous load, decrement and underflow detect.
// On underflow it wraps to all-ones or takes the supplied reload value.
module down_counter_cell
  import down_counter_74x191_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  cnt_t load_val,
  input  cnt_t reload_val,
  output cnt_t count,
  output logic underflow
);

  // An enabled step from zero is an underflow unless a load overrides it.
  assign underflow = ~load & en & (count == CNT_ZERO);

  // Count register: clear > load > underflow wrap/reload > decrement > hold.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (clr) begin
      count <= CNT_ZERO;
    end else if (load) begin
      count <= load_val;
    end else if (underflow) begin
      count <= AUTO_RELOAD ? reload_val : CNT_MAX;
    end else if (en) begin
      count <= count - cnt_t'(1);
    end
  end

endmodule : down_counter_cell

// File: rtl/down_counter_74x191.sv
// 74x191-style 4-bit down counter with optional auto-reload divider mode,
// registered terminal-count pulse and combinational ripple borrow out.
module down_counter_74x191
  import down_counter_74x191_pkg::*;
#(
  parameter bit   AUTO_RELOAD = 1'b0,
  parameter cnt_t RELOAD_INIT = 4'b1111
) (
  input  logic clk,
  input  logic clr,
  input  logic ld_bar,
  input  logic ent,
  input  logic enp,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic qa,
  output logic qb,
  output logic qc,
  output logic qd,
  output logic rbo,
  output logic tc
);

  cnt_t load_val;
  cnt_t reload_q;
  cnt_t count;
  logic load;
  logic count_enable;
  logic underflow;

  assign load_val     = {d, c, b, a};
  assign load         = ~ld_bar;
  assign count_enable = ent & enp;

  down_counter_cell #(
    .AUTO_RELOAD(AUTO_RELOAD)
  ) u_cell (
    .clk       (clk),
    .clr       (clr),
    .load      (load),
    .en        (count_enable),
    .load_val  (load_val),
    .reload_val(reload_q),
    .count     (count),
    .underflow (underflow)
  );

  // Reload register: captures every parallel load, otherwise holds.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      reload_q <= RELOAD_INIT;
    end else if (load) begin
      reload_q <= load_val;
    end
  end

  // Terminal count: one-cycle pulse registered from the underflow step.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tc <= 1'b0;
    end else begin
      tc <= underflow;
    end
  end

  // Ripple borrow is gated by ent only so stages can be cascaded.
  assign rbo = ent & (count == CNT_ZERO);

  assign {qd, qc, qb, qa} = count;

endmodule : down_counter_74x191

// File: tb/tb_down_counter_74x191.sv
// Self-checking bench: two instances (wrap and auto-reload) share stimulus;
// a behavioural model is compared every cycle and directed literals pin it.
module tb_down_counter_74x191;

  logic       clk;
  logic       clr;
  logic       ld_bar;
  logic       ent;
  logic       enp;
  logic [3:0] data;

  logic [3:0] q0, q1;
  logic       rbo0, rbo1, tc0, tc1;

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;

  // Behavioural model state: index 0 = wrap mode, index 1 = auto-reload mode.
  int m_cnt [2];
  int m_rel [2];
  int m_tc  [2];

  down_counter_74x191 #(.AUTO_RELOAD(1'b0), .RELOAD_INIT(4'b1111)) dut0 (
    .clk(clk), .clr(clr), .ld_bar(ld_bar), .ent(ent), .enp(enp),
    .a(data[0]), .b(data[1]), .c(data[2]), .d(data[3]),
    .qa(q0[0]), .qb(q0[1]), .qc(q0[2]), .qd(q0[3]),
    .rbo(rbo0), .tc(tc0)
  );

  down_counter_74x191 #(.AUTO_RELOAD(1'b1), .RELOAD_INIT(4'b1111)) dut1 (
    .clk(clk), .clr(clr), .ld_bar(ld_bar), .ent(ent), .enp(enp),
    .a(data[0]), .b(data[1]), .c(data[2]), .d(data[3]),
    .qa(q1[0]), .qb(q1[1]), .qc(q1[2]), .qd(q1[3]),
    .rbo(rbo1), .tc(tc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: value semantics of load / step-down / underflow straight from the rules.
  always @(posedge clk or posedge clr) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_cnt[i] <= 0;
        m_rel[i] <= 15;
        m_tc[i]  <= 0;
      end else if (ld_bar == 1'b0) begin
        m_cnt[i] <= int'(data);
        m_rel[i] <= int'(data);
        m_tc[i]  <= 0;
      end else if (ent && enp) begin
        if (m_cnt[i] == 0) begin
          m_cnt[i] <= (i == 1) ? m_rel[i] : 15;
          m_tc[i]  <= 1;
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
          m_tc[i]  <= 0;
        end
      end else begin
        m_tc[i] <= 0;
      end
    end
  end

  // Compare process: every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (started) begin
      check("model_cnt0", int'(q0), m_cnt[0]);
      check("model_tc0",  int'(tc0), m_tc[0]);
      check("model_rbo0", int'(rbo0), (ent && m_cnt[0] == 0) ? 1 : 0);
      check("model_cnt1", int'(q1), m_cnt[1]);
      check("model_tc1",  int'(tc1), m_tc[1]);
      check("model_rbo1", int'(rbo1), (ent && m_cnt[1] == 0) ? 1 : 0);
    end
  end

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [3:0] v);
    ld_bar = 1'b0;
    data   = v;
    cyc();
    ld_bar = 1'b1;
  endtask

  int tc_hits;
  int last_hit;

  initial begin
    ld_bar = 1'b1; ent = 1'b0; enp = 1'b0; data = 4'h0;
    clr = 1'b1;
    #12;
    check("reset_cnt", int'(q0), 0);
    check("reset_tc",  int'(tc0), 0);
    check("reset_rbo_ent0", int'(rbo0), 0);
    ent = 1'b1;
    #1;
    check("reset_rbo_ent1", int'(rbo0), 1);
    @(negedge clk);
    clr = 1'b0;
    started = 1'b1;

    // Async clear between edges from count 0110.
    load_val(4'b0110);
    check("pre_clr_cnt", int'(q0), 6);
    #2;
    clr = 1'b1;
    #1;
    check("async_clr_cnt", int'(q0), 0);
    check("async_clr_tc",  int'(tc0), 0);
    check("async_clr_rbo", int'(rbo0), int'(ent));
    #1;
    clr = 1'b0;

    // Free count in wrap mode from 0011.
    ent = 1'b1; enp = 1'b1;
    load_val(4'b0011);
    cyc(); check("free_2", int'(q0), 2);  check("free_2_rbo", int'(rbo0), 0);
    cyc(); check("free_1", int'(q0), 1);
    cyc(); check("free_0", int'(q0), 0);  check("free_0_rbo", int'(rbo0), 1);
    check("free_0_tc", int'(tc0), 0);
    cyc(); check("free_f", int'(q0), 15); check("free_f_tc", int'(tc0), 1);
    check("free_f_rbo", int'(rbo0), 0);
    check("reload_mode_reload", int'(q1), 3);
    cyc(); check("free_e", int'(q0), 14); check("free_e_tc", int'(tc0), 0);

    // Enable gating: enp low holds the count.
    load_val(4'b0101);
    enp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_cnt", int'(q0), 5);
      check("hold_tc",  int'(tc0), 0);
    end
    load_val(4'b0000);
    ent = 1'b0;
    #1;
    check("rbo_ent0", int'(rbo0), 0);
    ent = 1'b1;
    #1;
    check("rbo_ent1_enp0", int'(rbo0), 1);

    // Load colliding with an underflow: load wins, no tc.
    enp = 1'b1;
    load_val(4'b1010);
    check("collide_cnt", int'(q0), 10);
    check("collide_tc",  int'(tc0), 0);

    // Divider mode: reload 0100 gives a tc pulse every 5 enabled cycles.
    load_val(4'b0100);
    tc_hits = 0;
    last_hit = -1;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (tc1) begin
        if (last_hit >= 0) check("div_period", i - last_hit, 5);
        last_hit = i;
        tc_hits++;
        check("div_reload_cnt", int'(q1), 4);
      end
    end
    check("div_pulses", tc_hits, 3);

    // Reload value 0: every enabled cycle underflows, tc stays high.
    load_val(4'b0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("zero_reload_cnt", int'(q1), 0);
      check("zero_reload_tc",  int'(tc1), 1);
    end

    // Reset mid-count in auto-reload mode.
    load_val(4'b0111);
    cyc(); cyc();
    check("mid_cnt", int'(q1), 5);
    #2;
    clr = 1'b1;
    #1;
    check("mid_clr_cnt", int'(q1), 0);
    #1;
    clr = 1'b0;
    cyc();
    check("post_clr_cnt1", int'(q1), 15);
    check("post_clr_tc1",  int'(tc1), 1);
    check("post_clr_cnt0", int'(q0), 15);
    cyc();
    check("post_clr_next", int'(q1), 14);
    check("post_clr_tc_end", int'(tc1), 0);

    @(negedge clk);
    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_down_counter_74x191
